// File: rtl/aes_key_store_if.sv
// Round-key read port between the key store and the round datapath.
// The datapath is the master; the key store is the slave.
interface aes_key_store_if #(
    parameter int KEY_W = 128
);
    logic             rd_en;
    logic [3:0]       rd_addr;
    logic [KEY_W-1:0] rd_data;
    logic             rd_err;

    modport master (
        output rd_en, rd_addr,
        input  rd_data, rd_err
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data, rd_err
    );
endinterface

// File: rtl/aes_key_store.sv
// AES-128 round-key store: runs the key expansion unit once per key_load,
// captures round keys 0..NR and serves them through a registered read port.
module aes_key_store #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    output logic             exp_valid,
    output logic             exp_en,
    output logic [KEY_W-1:0] exp_key,
    input  logic [KEY_W-1:0] rk_in,
    output logic             busy,
    output logic             keys_ready,
    aes_key_store_if.slave   rd
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        EXPAND,
        READY
    } state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t           state;
    logic [3:0]       cnt;
    logic [KEY_W-1:0] slot [0:NR];
    logic             load_go;
    logic             rd_ok;

    assign load_go = key_load && (state == IDLE || state == READY);
    assign rd_ok   = keys_ready && (rd.rd_addr <= LAST);

    // Sequencer: start strobe, advance strobes, then READY until reload.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            exp_valid  <= 1'b0;
            exp_en     <= 1'b0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            exp_key    <= '0;
        end else begin
            exp_valid <= 1'b0;
            unique case (state)
                IDLE, READY: begin
                    if (key_load) begin
                        exp_key    <= key_in;
                        keys_ready <= 1'b0;
                        exp_valid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    cnt    <= 4'd1;
                    exp_en <= (4'd1 < LAST);
                    state  <= EXPAND;
                end
                EXPAND: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        exp_en     <= 1'b0;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                        state      <= READY;
                    end else begin
                        cnt    <= cnt + 4'd1;
                        exp_en <= (cnt + 4'd1) < LAST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Round-key capture; contents survive reset but are gated by keys_ready.
    always_ff @(posedge CLK) begin
        if (rst_n) begin
            if (load_go) begin
                slot[0] <= key_in;
            end
            if (state == EXPAND) begin
                slot[cnt] <= rk_in;
            end
        end
    end

    // Registered read port, judged on pre-edge keys_ready.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            rd.rd_data <= '0;
            rd.rd_err  <= 1'b0;
        end else if (rd.rd_en) begin
            if (rd_ok) begin
                rd.rd_data <= slot[rd.rd_addr];
                rd.rd_err  <= 1'b0;
            end else begin
                rd.rd_data <= '0;
                rd.rd_err  <= 1'b1;
            end
        end else begin
            rd.rd_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_store.sv
// Bench for aes_key_store: behavioural expansion unit, schedule model
// and randomized load/read traffic.
module tb_aes_key_store;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [127:0] key_in;
    logic         exp_valid;
    logic         exp_en;
    logic [127:0] exp_key;
    logic [127:0] rk_in;
    logic         busy;
    logic         keys_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] sched_m [0:10];
    bit           ready_m = 1'b0;

    logic [127:0] rk_model = '0;
    int           rnd_m = 1;

    aes_key_store_if #(.KEY_W(128)) rif ();

    aes_key_store dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_in     (key_in),
        .exp_valid  (exp_valid),
        .exp_en     (exp_en),
        .exp_key    (exp_key),
        .rk_in      (rk_in),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rd         (rif.slave)
    );

    always #5 CLK = ~CLK;

    assign rk_in = rk_model;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                      ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]],
                sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] p,
                                             input int r);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t, n0, n1, n2, n3;
        for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
        t  = sub_word({p[23:0], p[31:24]}) ^ {rc, 24'h0};
        n0 = p[127:96] ^ t;
        n1 = p[95:64] ^ n0;
        n2 = p[63:32] ^ n1;
        n3 = p[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Expansion unit: Valid loads round 1, each En_Exp advances one round.
    always @(posedge CLK) begin
        if (exp_valid) begin
            rk_model <= next_rk(exp_key, 1);
            rnd_m    <= 2;
        end else if (exp_en) begin
            rk_model <= next_rk(rk_model, rnd_m);
            rnd_m    <= rnd_m + 1;
        end
    end

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rd_chk(input logic [3:0] a);
        bit           ok;
        logic [127:0] ed;
        ok = ready_m && (a <= 4'd10);
        ed = ok ? sched_m[a] : '0;
        @(negedge CLK);
        rif.rd_en   = 1'b1;
        rif.rd_addr = a;
        @(negedge CLK);
        rif.rd_en = 1'b0;
        chk($sformatf("rd_data[%0d]", a), rif.rd_data, ed);
        chk($sformatf("rd_err[%0d]", a), rif.rd_err, !ok);
        @(negedge CLK);
        chk("rd_hold", rif.rd_data, ed);
        chk("rd_err_idle", rif.rd_err, 1'b0);
    endtask

    task automatic rd_lit(input logic [3:0] a, input logic [127:0] lit);
        @(negedge CLK);
        rif.rd_en   = 1'b1;
        rif.rd_addr = a;
        @(negedge CLK);
        rif.rd_en = 1'b0;
        chk($sformatf("fips_rk[%0d]", a), rif.rd_data, lit);
        chk($sformatf("fips_err[%0d]", a), rif.rd_err, 1'b0);
    endtask

    // One load; k counts cycles after the load edge c.
    task automatic load_run(input logic [127:0] key, input int dup_at,
                            input int rd_at, input logic [3:0] ra,
                            input int rst_at);
        logic [127:0] nsch [0:10];
        logic [127:0] ed;
        bit           rdy_pre, ok;
        int           nv, ne, nb, rdy_at;
        nsch[0] = key;
        for (int i = 1; i <= 10; i++) nsch[i] = next_rk(nsch[i-1], i);
        rdy_pre = (rd_at == 0) ? ready_m : (rd_at >= 12);
        ok = rdy_pre && (ra <= 4'd10);
        if (!ok) ed = '0;
        else if (rd_at == 0) ed = sched_m[ra];
        else ed = nsch[ra];
        nv = 0; ne = 0; nb = 0; rdy_at = 0;
        @(negedge CLK);
        key_load = 1'b1;
        key_in   = key;
        rif.rd_en   = (rd_at == 0);
        rif.rd_addr = ra;
        for (int k = 1; k <= 13; k++) begin
            @(negedge CLK);
            key_load    = (k == dup_at);
            key_in      = rand_key();
            rif.rd_en   = (k == rd_at);
            if (k == rd_at + 1) begin
                chk("ld_rd_data", rif.rd_data, ed);
                chk("ld_rd_err", rif.rd_err, !ok);
            end
            if (k == rst_at + 1) begin
                chk("rst_exp_valid", exp_valid, 1'b0);
                chk("rst_exp_en", exp_en, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_keys_ready", keys_ready, 1'b0);
                chk("rst_exp_key", exp_key, '0);
                chk("rst_rd_data", rif.rd_data, '0);
                chk("rst_rd_err", rif.rd_err, 1'b0);
                rst_n   = 1'b1;
                ready_m = 1'b0;
                return;
            end
            if (k == rst_at) rst_n = 1'b0;
            chk($sformatf("exp_valid@%0d", k), exp_valid, k == 1);
            chk($sformatf("exp_en@%0d", k), exp_en, k >= 2 && k <= 10);
            chk($sformatf("busy@%0d", k), busy, k <= 11);
            chk($sformatf("keys_ready@%0d", k), keys_ready, k >= 12);
            if (exp_valid) nv++;
            if (exp_en) ne++;
            if (busy) nb++;
            if (keys_ready && rdy_at == 0) rdy_at = k;
        end
        chk("n_valid", 32'(nv), 32'd1);
        chk("n_en", 32'(ne), 32'd9);
        chk("n_busy", 32'(nb), 32'd11);
        chk("ready_at", 32'(rdy_at), 32'd12);
        for (int i = 0; i <= 10; i++) sched_m[i] = nsch[i];
        ready_m = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        key_load    = 1'b0;
        key_in      = '0;
        rif.rd_en   = 1'b0;
        rif.rd_addr = '0;
        build_sbox();
        repeat (3) @(negedge CLK);
        chk("reset_exp_valid", exp_valid, 1'b0);
        chk("reset_exp_en", exp_en, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_keys_ready", keys_ready, 1'b0);
        chk("reset_exp_key", exp_key, '0);
        chk("reset_rd_data", rif.rd_data, '0);
        chk("reset_rd_err", rif.rd_err, 1'b0);
        rst_n = 1'b1;

        rd_chk(4'd0);

        load_run(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, -1, 4'd0, -1);
        rd_lit(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_lit(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_lit(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_chk(4'd11);
        rd_chk(4'd15);
        rd_chk(4'd5);

        load_run(rand_key(), -1, 3, 4'd3, -1);
        load_run(rand_key(), 5, -1, 4'd0, -1);
        rd_chk(4'd7);

        load_run(rand_key(), -1, -1, 4'd0, 6);
        rd_chk(4'd2);
        load_run(128'h000102030405060708090a0b0c0d0e0f, -1, -1, 4'd0, -1);
        rd_lit(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        load_run(rand_key(), -1, 0, 4'd0, -1);
        rd_chk(4'd0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                load_run(rand_key(), -1, -1, 4'd0, -1);
            end else begin
                rd_chk(4'($urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
